// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader: assembles little-endian 32-bit words from received bytes
// and writes them into instruction memory while load mode is enabled.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 7,
  parameter int MAX_WORDS    = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W   = ADDR_W + 1;
  localparam logic [TIMER_W-1:0] T_HALF = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [7:0]         rx_byte;
  logic [31:0]        asm_word;
  logic               rx_s1, rx_s2, rx_d;
  logic               load_en_d;
  logic [CNT_W-1:0]   cnt_next;

  assign busy_o   = load_en_i & ~done_o;
  assign cnt_next = word_cnt_o + CNT_W'(1);

  // The line-idle level (1) is loaded into the synchronizer on reset so that
  // releasing reset never looks like a start-bit falling edge.
  // NOTE: the assembly/shift registers are datapath only, yet they are reset too,
  // giving deterministic write data after reset at negligible cost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_d         <= 1'b1;
      load_en_d    <= 1'b0;
      state        <= IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      rx_byte      <= '0;
      asm_word     <= '0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      word_cnt_o   <= '0;
      done_o       <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees the
      // value from before this edge regardless of statement order.
      rx_s1     <= uart_rx_i;
      rx_s2     <= rx_s1;
      rx_d      <= rx_s2;
      load_en_d <= load_en_i;
      imem_we_o <= 1'b0;

      if (imem_we_o) begin
        word_cnt_o <= cnt_next;
        if (cnt_next == CNT_W'(MAX_WORDS)) done_o <= 1'b1;
      end

      if (!load_en_i) begin
        state    <= IDLE;
        timer    <= '0;
        byte_idx <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!done_o && rx_d && !rx_s2) begin
              state <= START;
              timer <= '0;
            end
          end
          START: begin
            if (timer == T_HALF) begin
              timer   <= '0;
              bit_idx <= '0;
              state   <= rx_s2 ? IDLE : DATA;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          DATA: begin
            if (timer == T_LAST) begin
              timer   <= '0;
              rx_byte <= {rx_s2, rx_byte[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          STOP: begin
            if (timer == T_LAST) begin
              timer <= '0;
              state <= IDLE;
              if (rx_s2) begin
                asm_word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                byte_idx <= byte_idx + 2'd1;
                // Fourth byte goes straight into the write data, bypassing asm_word.
                if (byte_idx == 2'd3) begin
                  imem_we_o    <= 1'b1;
                  imem_wdata_o <= {rx_byte, asm_word[23:0]};
                  imem_addr_o  <= word_cnt_o[ADDR_W-1:0];
                end
              end else begin
                frame_err_o <= 1'b1;
                byte_idx    <= '0;
              end
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (load_en_i && !load_en_d) begin
        word_cnt_o  <= '0;
        done_o      <= 1'b0;
        frame_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader: byte-level reference model feeds an expected-write
// queue; a negedge monitor pops it on every write strobe.
module tb_imem_uart_loader;
  localparam int CPB    = 16;
  localparam int ADDR_W = 7;
  localparam int MAXW   = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              uart_rx_i;
  logic              load_en_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              frame_err_o;
  logic [ADDR_W:0]   word_cnt_o;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rstn(rstn), .uart_rx_i(uart_rx_i), .load_en_i(load_en_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .frame_err_o(frame_err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_bytes[$];
  int         m_cnt;
  bit         m_done, m_ferr, m_load;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a good byte joins the pending word; four bytes make one write.
  function automatic void m_byte(input logic [7:0] b, input bit good);
    exp_t e;
    if (!m_load || m_done) return;
    if (!good) begin
      m_ferr = 1'b1;
      m_bytes.delete();
      return;
    end
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      e.addr = ADDR_W'(m_cnt);
      e.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      exp_q.push_back(e);
      m_bytes.delete();
      m_cnt++;
      if (m_cnt == MAXW) m_done = 1'b1;
    end
  endfunction

  // Monitor
  exp_t              mon_e;
  bit                post_pending = 1'b0;
  logic [ADDR_W:0]   post_cnt;

  always @(negedge clk) begin
    if (post_pending) begin
      check("strobe_width", imem_we_o, 0);
      check("cnt_after_strobe", word_cnt_o, post_cnt);
      post_pending = 1'b0;
    end else if (rstn && imem_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", imem_addr_o, {ADDR_W{1'b1}});
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", imem_addr_o, mon_e.addr);
        check("strobe_data", imem_wdata_o, mon_e.data);
        post_cnt     = {1'b0, mon_e.addr} + 1'b1;
        post_pending = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit good);
    m_byte(b, good);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_i = good;
    repeat (CPB) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat ($urandom_range(12, 2)) @(negedge clk);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
  endtask

  task automatic set_load(input bit v);
    load_en_i = v;
    if (v && !m_load) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_ferr = 1'b0;
    end
    if (!v) m_bytes.delete();
    m_load = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic reload();
    set_load(1'b0);
    set_load(1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending_writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_word_cnt"}, word_cnt_o, m_cnt);
    check({tag, "_done"}, done_o, m_done);
    check({tag, "_frame_err"}, frame_err_o, m_ferr);
    check({tag, "_busy"}, busy_o, m_load && !m_done);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, imem_we_o, 0);
    check({tag, "_addr"}, imem_addr_o, 0);
    check({tag, "_wdata"}, imem_wdata_o, 0);
    check({tag, "_word_cnt"}, word_cnt_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_frame_err"}, frame_err_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    rstn = 1'b0; uart_rx_i = 1'b1; load_en_i = 1'b0;
    m_load = 1'b0; m_cnt = 0; m_done = 1'b0; m_ferr = 1'b0;
    #12;
    check_reset_outputs("reset");
    check("reset_busy", busy_o, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Single known word
    set_load(1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    drain();
    check_state("single");

    // Full load, then one extra byte that must be ignored
    reload();
    send_rand(16);
    drain();
    check_state("full");
    send_rand(1);
    drain();
    check_state("after_full");

    // Bad stop bit, then a clean word
    reload();
    send_byte(8'hAA, 1'b0);
    check_state("frame_err");
    send_rand(4);
    drain();
    check_state("after_frame_err");

    // Short low glitch in idle
    reload();
    uart_rx_i = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");
    send_rand(4);
    drain();
    check_state("after_glitch");

    // Load-enable abort after a partial word
    reload();
    send_rand(4);
    send_rand(2);
    set_load(1'b0);
    check_state("abort_hold");
    set_load(1'b1);
    check_state("abort_reraise");
    send_rand(4);
    drain();
    check_state("after_abort");

    // Reset in the middle of data bit 3
    reload();
    send_rand(4);
    drain();
    b = 8'($urandom);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_i = b[3];
    repeat (CPB / 2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    m_cnt = 0; m_done = 1'b0; m_ferr = 1'b0; m_bytes.delete();
    repeat (5) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    send_rand(4);
    drain();
    check_state("after_reset");

    // Randomized mixes of good and bad bytes
    for (int r = 0; r < 3; r++) begin
      reload();
      for (int k = 0, n = $urandom_range(10, 1); k < n; k++)
        send_byte(8'($urandom), $urandom_range(9, 0) != 0);
      drain();
      check_state("random_mix");
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
